dmem_responder: RTL and testbench

Word-addressed data-memory responder. It serves the processor's load/store requests over a valid/ready request channel and a valid/ready response channel. A configurable number of wait states models a slow memory, so the pipeline's memory stage can be exercised against non-zero latency. The block is the memory-side end of the MemRead/MemWrite interface the core issues.

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a valid/ready request/response pair and a
// fixed number of wait states between request accept and response.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and ready is only high in S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        accept;
  logic        enter_resp;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [IDX_W-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  assign req_ready = (state == S_IDLE) && rst_n;
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // live request fields are used before they reach the capture registers.
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
  assign acc_idx = acc_addr[IDX_W+1:2];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'h0;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

  // The array has no reset; contents survive rst_n and start undefined.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !acc_err) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance and a 0-wait-state
// instance checked against an associative-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        z_req_valid, z_req_write, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_ready(z_req_ready),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_mem [int];
  logic [32:0] exp_q[$];

  // Reference: a word store keyed by word index; errors never touch it.
  function automatic void model_req(input logic w, input logic [31:0] addr,
                                    input logic [31:0] wd,
                                    output logic [31:0] rd, output logic e);
    int unsigned word;
    word = addr / 4;
    e    = (addr % 4 != 0) || (word >= DEPTH);
    rd   = 32'h0;
    if (!e && w) ref_mem[int'(word)] = wd;
    if (!e && !w && ref_mem.exists(int'(word))) rd = ref_mem[int'(word)];
  endfunction

  task automatic a_txn(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat);
    int guard;
    guard = 0;
    a_req_write = w;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_rsp_ready = 1'b1;
    while (!a_req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!a_rsp_valid) begin
      n_checks++; n_errors++;
      $display("FAIL txn_timeout: rsp_valid=%0b required 1", a_rsp_valid);
    end
    rd = a_rsp_rdata;
    e  = a_rsp_err;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_rsp_ready = 0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (a_req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req_ready: got %b want 0", a_req_ready); end
    n_checks++;
    if (a_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", a_rsp_valid); end
    n_checks++;
    if (a_rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %h want 0", a_rsp_rdata); end
    n_checks++;
    if ({a_rsp_err, z_rsp_valid, z_req_ready} !== 3'b000) begin
      n_errors++; $display("FAIL reset_misc: got %b want 000", {a_rsp_err, z_rsp_valid, z_req_ready});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_req_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready: got %b want 1", a_req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model_req(1'b1, 32'h10, 32'hDEADBEEF, erd, ee);
    a_txn(1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat);
    n_checks++;
    if (lat != WS) begin n_errors++; $display("FAIL store_latency: got %0d want %0d", lat, WS); end
    n_checks++;
    if ({e, rd} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL store_rsp: err=%b rdata=%h want 0/0", e, rd); end
    model_req(1'b0, 32'h10, 32'h0, erd, ee);
    a_txn(1'b0, 32'h10, 32'h0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {ee, erd}) begin n_errors++; $display("FAIL load_after_store: err=%b rdata=%h want %b/%h", e, rd, ee, erd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic e, ee; int lat;
    a_txn(1'b0, 32'h13, 32'h0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL misaligned_load: err=%b rdata=%h want 1/0", e, rd); end
    model_req(1'b1, 32'h0, 32'h12345678, erd, ee);
    a_txn(1'b1, 32'h0, 32'h12345678, rd, e, lat);
    model_req(1'b1, 32'h400, 32'hBAD0BAD0, erd, ee);
    a_txn(1'b1, 32'h400, 32'hBAD0BAD0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL range_store: err=%b rdata=%h want 1/0", e, rd); end
    model_req(1'b0, 32'h0, 32'h0, erd, ee);
    a_txn(1'b0, 32'h0, 32'h0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {ee, erd}) begin n_errors++; $display("FAIL word0_unchanged: err=%b rdata=%h want %b/%h", e, rd, ee, erd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] erd, hold_rd; logic ee, hold_err; int guard;
    model_req(1'b0, 32'h10, 32'h0, erd, ee);
    a_rsp_ready = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h10; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    guard = 0;
    while (!a_rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    hold_rd = a_rsp_rdata; hold_err = a_rsp_err;
    n_checks++;
    if ({a_rsp_valid, hold_err, hold_rd} !== {1'b1, ee, erd}) begin
      n_errors++; $display("FAIL bp_first: valid=%b err=%b rdata=%h want 1/%b/%h", a_rsp_valid, hold_err, hold_rd, ee, erd);
    end
    for (int i = 0; i < 5; i++) begin
      a_req_valid = 1'($urandom_range(0, 1));
      a_req_write = 1'($urandom_range(0, 1));
      a_req_addr  = 32'($urandom_range(0, 15)) << 2;
      a_req_wdata = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if ({a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata} !== {1'b1, 1'b0, hold_err, hold_rd}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b err=%b rdata=%h want 1/0/%b/%h",
                 i, a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata, hold_err, hold_rd);
      end
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    n_checks++;
    if ({a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL bp_release: valid=%b ready=%b err=%b rdata=%h want 0/1/0/0",
               a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata);
    end
  endtask

  task automatic test_ws0();
    logic [31:0] d, ld; logic got; int acc_cyc[2]; int acc_cnt;
    d = $urandom; got = 1'b0; ld = 32'h0; acc_cnt = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    z_rsp_ready = 1'b1; z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8; z_req_wdata = d;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (z_req_valid && z_req_ready && acc_cnt < 2) begin acc_cyc[acc_cnt] = cyc; acc_cnt++; end
      @(posedge clk); #1;
      if (acc_cnt == 1 && z_req_write) begin
        n_checks++;
        if ({z_rsp_valid, z_rsp_err, z_rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
          n_errors++; $display("FAIL ws0_store_rsp: valid=%b err=%b rdata=%h want 1/0/0", z_rsp_valid, z_rsp_err, z_rsp_rdata);
        end
        z_req_write = 1'b0;
        z_req_wdata = $urandom;
      end else if (acc_cnt == 2 && z_req_valid) begin
        z_req_valid = 1'b0;
        got = z_rsp_valid;
        ld  = z_rsp_rdata;
      end
    end
    n_checks++;
    if (acc_cnt != 2 || acc_cyc[1] - acc_cyc[0] != 2) begin
      n_errors++; $display("FAIL ws0_spacing: accepts=%0d spacing=%0d want 2/2", acc_cnt, acc_cyc[1] - acc_cyc[0]);
    end
    n_checks++;
    if ({got, ld} !== {1'b1, d}) begin n_errors++; $display("FAIL ws0_load: valid=%b rdata=%h want 1/%h", got, ld, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model_req(1'b1, 32'h20, 32'h11111111, erd, ee);
    a_txn(1'b1, 32'h20, 32'h11111111, rd, e, lat);
    a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata} !== 35'h0) begin
      n_errors++; $display("FAIL reset_mid_outputs: ready=%b valid=%b err=%b rdata=%h want all 0",
                           a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mid_no_rsp: valid=%b want 0", a_rsp_valid); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_req(1'b0, 32'h20, 32'h0, erd, ee);
    a_txn(1'b0, 32'h20, 32'h0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {ee, erd}) begin n_errors++; $display("FAIL reset_mid_load: err=%b rdata=%h want %b/%h", e, rd, ee, erd); end
  endtask

  task automatic test_boundary();
    logic [31:0] rd, erd, d; logic e, ee; int lat;
    d = $urandom;
    model_req(1'b1, 32'h3FC, d, erd, ee);
    a_txn(1'b1, 32'h3FC, d, rd, e, lat);
    n_checks++;
    if (e !== 1'b0) begin n_errors++; $display("FAIL last_word_store: err=%b want 0", e); end
    model_req(1'b0, 32'h3FC, 32'h0, erd, ee);
    a_txn(1'b0, 32'h3FC, 32'h0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {1'b0, d}) begin n_errors++; $display("FAIL last_word_load: err=%b rdata=%h want 0/%h", e, rd, d); end
    a_txn(1'b0, 32'hFFFFFFFC, 32'h0, rd, e, lat);
    n_checks++;
    if ({e, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL top_addr: err=%b rdata=%h want 1/0", e, rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, d, tmp; logic e, ee, w; int lat; int kind; logic [32:0] exp;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model_req(1'b1, 32'(i) << 2, d, erd, ee);
      a_txn(1'b1, 32'(i) << 2, d, rd, e, lat);
    end
    for (int i = 0; i < 24; i++) begin
      w    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      d    = $urandom;
      addr = 32'($urandom_range(0, 15)) << 2;
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (kind == 1) begin
        tmp  = 32'($urandom_range(DEPTH, 32'h3FFFFFFF));
        addr = tmp << 2;
      end
      model_req(w, addr, d, erd, ee);
      exp_q.push_back({ee, erd});
      a_txn(w, addr, d, rd, e, lat);
      exp = exp_q.pop_front();
      n_checks++;
      if ({e, rd} !== exp) begin
        n_errors++; $display("FAIL random[%0d] w=%b addr=%h: err=%b rdata=%h want %b/%h", i, w, addr, e, rd, exp[32], exp[31:0]);
      end
      n_checks++;
      if (lat != WS) begin n_errors++; $display("FAIL random_lat[%0d]: got %0d want %0d", i, lat, WS); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_ws0();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
